// File: rtl/mul_serial_acc.sv
// Shift-accumulating receiver for the binary-serial multiply stream.
// Sums one partial product per enabled step into a signed 2*WIDTH product, then holds it under valid/ready.
module mul_serial_acc #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr,
   input  logic [DEPTH-1:0]   i_idx,
   input  logic [2*WIDTH-1:0] i_pp,
   input  logic               i_ready,
   output logic               o_ready,
   output logic               o_valid,
   output logic [2*WIDTH-1:0] o_prod,
   output logic               o_err
);
   localparam int PW = 2 * WIDTH;
   localparam logic [DEPTH-1:0] LAST = DEPTH'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     prod_q, prod_d;
   logic [DEPTH-1:0]  idx_q, idx_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic [PW-1:0]     term, step_sum;

   // The sign-bit step carries negative weight in two's complement, hence the subtract.
   always_comb begin
      term     = i_pp << i_idx;
      step_sum = (i_idx == LAST) ? (acc_q - term) : (acc_q + term);
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               if (i_idx == '0) begin
                  acc_d   = term;
                  idx_d   = DEPTH'(1);
                  state_d = ACC;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ACC: begin
            // idx_q never exceeds WIDTH-1, so out-of-range indices always mismatch.
            if (en) begin
               if (i_idx != idx_q) begin
                  err_d = 1'b1;
               end else if (i_idx == LAST) begin
                  prod_d  = step_sum;
                  valid_d = 1'b1;
                  acc_d   = '0;
                  idx_d   = '0;
                  state_d = HOLD;
               end else begin
                  acc_d = step_sum;
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (en) err_d = 1'b1;
            if (i_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (clr) begin
         state_d = IDLE;
         acc_d   = '0;
         idx_d   = '0;
         valid_d = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         prod_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign o_ready = (state_q != HOLD);
   assign o_valid = valid_q;
   assign o_prod  = prod_q;
   assign o_err   = err_q;
endmodule

// File: tb/tb_mul_serial_acc.sv
// Scoreboard bench for mul_serial_acc: stimulus queues expected products, monitor checks handshakes.
module tb_mul_serial_acc;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0, clr = 1'b0, i_ready = 1'b1;
   logic [3:0]  i_idx = '0;
   logic [31:0] i_pp = '0;
   logic        o_ready, o_valid, o_err;
   logic [31:0] o_prod;

   int checks = 0;
   int fails  = 0;
   logic [31:0] exp_q[$];

   mul_serial_acc #(.WIDTH(16), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .i_idx(i_idx), .i_pp(i_pp),
      .i_ready(i_ready), .o_ready(o_ready), .o_valid(o_valid), .o_prod(o_prod), .o_err(o_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: pops on each handshake, and checks HOLD invariants.
   logic        prev_valid = 1'b0;
   logic [31:0] prev_prod = '0;
   always @(negedge clk) begin
      if (!rst) begin
         if (o_valid) begin
            chk("hold_ready_low", {31'd0, o_ready}, 32'd0);
            if (prev_valid) chk("hold_prod_stable", o_prod, prev_prod);
         end
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) chk("unexpected_product", o_prod, 32'hxxxxxxxx);
            else chk("product", o_prod, exp_q.pop_front());
         end
      end
      prev_valid = o_valid;
      prev_prod  = o_prod;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!o_ready && n < 50) begin
         tick();
         n++;
      end
      if (!o_ready) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic step(input logic [3:0] idx, input logic [31:0] pp, input bit bub);
      wait_ready();
      if (bub) begin
         en = 1'b0;
         repeat ($urandom_range(0, 1)) tick();
      end
      en = 1'b1; i_idx = idx; i_pp = pp;
      tick();
      en = 1'b0;
   endtask

   // Issues steps lo..hi of a*b; a is the serial multiplier, b the multiplicand.
   task automatic steps(input logic [15:0] a, input logic [15:0] b, input int lo, input int hi, input bit bub);
      logic [31:0] bx;
      bx = {{16{b[15]}}, b};
      for (int i = lo; i <= hi; i++) step(4'(i), a[i] ? bx : 32'd0, bub);
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp, input bit bub);
      exp_q.push_back(exp);
      steps(a, b, 0, 15, bub);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_prod",  o_prod, 32'd0);
      chk("rst_err",   {31'd0, o_err}, 32'd0);
      chk("rst_ready", {31'd0, o_ready}, 32'd1);

      // 3 x 5 with latency: valid only after the 16th step
      exp_q.push_back(32'd15);
      steps(16'd3, 16'd5, 0, 14, 1'b0);
      chk("lat_not_yet", {31'd0, o_valid}, 32'd0);
      steps(16'd3, 16'd5, 15, 15, 1'b0);
      chk("lat_valid", {31'd0, o_valid}, 32'd1);

      send(16'hFFFD, 16'd5,    32'hFFFFFFF1, 1'b0);
      send(16'h8000, 16'h8000, 32'h40000000, 1'b0);
      send(16'h7FFF, 16'h8000, 32'hC0008000, 1'b0);
      send(16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0);
      send(16'd100,  16'hFFF9, 32'hFFFFFD44, 1'b0);
      send(16'd0,    16'd1234, 32'h00000000, 1'b0);

      // bubbles on input, downstream stalls 5 cycles in HOLD
      wait_ready();
      i_ready = 1'b0;
      send(16'hFFFD, 16'd5, 32'hFFFFFFF1, 1'b1);
      repeat (5) begin
         chk("stall_ready", {31'd0, o_ready}, 32'd0);
         chk("stall_valid", {31'd0, o_valid}, 32'd1);
         tick();
      end
      i_ready = 1'b1;
      send(16'd3, 16'd5, 32'd15, 1'b1);
      wait_ready();
      chk("bubble_no_err", {31'd0, o_err}, 32'd0);

      // clr at idx 7 aborts the product
      steps(16'd3, 16'd5, 0, 6, 1'b0);
      clr = 1'b1;
      steps(16'd3, 16'd5, 7, 7, 1'b0);
      clr = 1'b0;
      chk("clr_valid", {31'd0, o_valid}, 32'd0);
      chk("clr_ready", {31'd0, o_ready}, 32'd1);
      send(16'd3, 16'd5, 32'd15, 1'b0);
      wait_ready();

      // async reset mid-ACC
      steps(16'd3, 16'd5, 0, 5, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_prod",  o_prod, 32'd0);
      chk("arst_valid", {31'd0, o_valid}, 32'd0);
      chk("arst_ready", {31'd0, o_ready}, 32'd1);
      tick();
      rst = 1'b0;

      // idx 0,1,3: error on the skip, then resume at 2
      steps(16'd3, 16'd5, 0, 1, 1'b0);
      chk("err_clean", {31'd0, o_err}, 32'd0);
      step(4'd3, 32'd0, 1'b0);
      chk("err_skip", {31'd0, o_err}, 32'd1);
      exp_q.push_back(32'd15);
      steps(16'd3, 16'd5, 2, 15, 1'b0);
      wait_ready();
      clr = 1'b1; tick(); clr = 1'b0;
      chk("err_clr", {31'd0, o_err}, 32'd0);

      // idle start with nonzero idx
      step(4'd4, 32'd5, 1'b0);
      chk("err_idle_idx", {31'd0, o_err}, 32'd1);
      clr = 1'b1; tick(); clr = 1'b0;

      // en while in HOLD
      i_ready = 1'b0;
      send(16'hFFFD, 16'd5, 32'hFFFFFFF1, 1'b0);
      en = 1'b1; i_idx = 4'd0; i_pp = 32'd7;
      tick();
      en = 1'b0;
      chk("hold_en_err",   {31'd0, o_err}, 32'd1);
      chk("hold_en_prod",  o_prod, 32'hFFFFFFF1);
      chk("hold_en_valid", {31'd0, o_valid}, 32'd1);
      i_ready = 1'b1;
      tick();
      clr = 1'b1; tick(); clr = 1'b0;
      chk("final_clr_err", {31'd0, o_err}, 32'd0);

      repeat (3) tick();
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
